// File: rtl/placement_pkg.sv
// placement_pkg: shared sizes, FSM encoding and strip record for the strip placement index
package placement_pkg;
  localparam int NUM_STRIPS  = 16;
  localparam int ID_W        = 4;
  localparam int WIDTH_W     = 8;
  localparam int STRIKE_W    = 4;
  localparam int STRIP_WIDTH = 200;
  localparam int STRIKE_MAX  = 3;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  typedef struct packed {
    logic [WIDTH_W-1:0]  occ;
    logic [STRIKE_W-1:0] strike;
  } strip_t;
  // Overfilled strips report zero free width rather than wrapping.
  function automatic logic [WIDTH_W:0] strip_free(input logic [WIDTH_W-1:0] occ);
    return (32'(occ) > STRIP_WIDTH) ? '0 : (WIDTH_W+1)'(STRIP_WIDTH - 32'(occ));
  endfunction
endpackage

// File: rtl/strip_status_table.sv
// strip_status_table: per-strip occupied/strike register file with same-cycle write bypass on the read port
module strip_status_table import placement_pkg::*; (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [ID_W-1:0]     wr_id,
  input  logic [WIDTH_W-1:0]  wr_occ,
  input  logic [STRIKE_W-1:0] wr_strike,
  input  logic [ID_W-1:0]     rd_id,
  output logic [WIDTH_W-1:0]  rd_occ,
  output logic [STRIKE_W-1:0] rd_strike
);
  strip_t r_table [NUM_STRIPS];
  logic   w_wr_ok;
  logic   w_byp;
  assign w_wr_ok   = wr_en && (32'(wr_id) < NUM_STRIPS);
  assign w_byp     = w_wr_ok && (wr_id == rd_id);
  assign rd_occ    = w_byp ? wr_occ : r_table[rd_id].occ;
  assign rd_strike = w_byp ? wr_strike : r_table[rd_id].strike;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_STRIPS; i++) r_table[i] <= '0;
    end else if (w_wr_ok) begin
      r_table[wr_id] <= '{occ: wr_occ, strike: wr_strike};
    end
  end
endmodule

// File: rtl/strip_index_reader.sv
// strip_index_reader: tracks strip status from write-stage updates and finds the lowest strip that fits a query
module strip_index_reader import placement_pkg::*; (
  input  logic                clk,
  input  logic                rstn,
  input  logic                upd_valid,
  input  logic [ID_W-1:0]     strip_ID_in,
  input  logic [WIDTH_W-1:0]  occupied_width_in,
  input  logic [STRIKE_W-1:0] strike_in,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WIDTH_W-1:0]  req_width,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [ID_W-1:0]     resp_strip_ID,
  output logic [WIDTH_W-1:0]  resp_free_width
);
  state_t              r_state;
  logic [ID_W-1:0]     r_idx;
  logic [WIDTH_W-1:0]  r_req_width;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic [ID_W-1:0]     r_resp_id;
  logic [WIDTH_W-1:0]  r_resp_free;
  logic [WIDTH_W-1:0]  w_occ;
  logic [STRIKE_W-1:0] w_strike;
  logic [WIDTH_W:0]    w_free;
  logic                w_fit;
  strip_status_table u_table (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (upd_valid),
    .wr_id     (strip_ID_in),
    .wr_occ    (occupied_width_in),
    .wr_strike (strike_in),
    .rd_id     (r_idx),
    .rd_occ    (w_occ),
    .rd_strike (w_strike)
  );
  assign w_free = strip_free(w_occ);
  assign w_fit  = ({1'b0, r_req_width} <= w_free) && (32'(w_strike) < STRIKE_MAX);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_req_width  <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_id    <= '0;
      r_resp_free  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_width <= req_width;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= SCAN;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        SCAN: begin
          if (w_fit || r_idx == ID_W'(NUM_STRIPS - 1)) begin
            r_resp_hit   <= w_fit;
            r_resp_id    <= w_fit ? r_idx : '0;
            r_resp_free  <= w_fit ? w_free[WIDTH_W-1:0] : '0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign req_ready       = r_req_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_hit        = r_resp_hit;
  assign resp_strip_ID   = r_resp_id;
  assign resp_free_width = r_resp_free;
endmodule
